// File: rtl/sseg_scan_ctrl_if.sv
// Score update channel for the seven-segment scan controller.
//
// Handshake: the producer drives in_data/in_valid; the controller drives
// in_ready. A word transfers on every clock edge where in_valid && in_ready
// are both high. The producer keeps in_valid and in_data stable until that
// edge. in_ready may fall while in_valid is held high; the word then waits
// and is never dropped.
//
// Signals:
//   in_data   16  BCD score {d3,d2,d1,d0}
//   in_valid   1  in_data holds a word to transfer
//   in_ready   1  controller can accept a word
interface sseg_scan_ctrl_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller (Basys3 display).
//
// Drives one digit per slot of SLOT_CYC clocks, with all anodes off for the
// first BLANK_CYC clocks of each slot to avoid ghosting. The score is held as
// four BCD nibbles. A new score is accepted over the update channel into a
// one-word holding register and copied to the displayed value only at the end
// of a full scan, so a single scan never mixes old and new digits.
// Optional leading-zero blanking on d3 and d1, and a whole-display blink with
// a half-period of BLINK_SCANS full scans.
//
// Ports:
//   clk       pixel clock
//   rst       asynchronous reset, active-high
//   bus       score update channel (slave side)
//   lz_en     blank d3 / d1 when they are zero
//   blink_en  make the whole display blink
//   an        anodes, active-low, an[k] = digit k, digit 0 rightmost
//   seg       cathodes, active-low, {g,f,e,d,c,b,a}
module sseg_scan_ctrl #(
    parameter int SLOT_CYC    = 65000,
    parameter int BLANK_CYC   = 64,
    parameter int BLINK_SCANS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    sseg_scan_ctrl_if.slave       bus,
    input  logic                  lz_en,
    input  logic                  blink_en,
    output logic [3:0]            an,
    output logic [6:0]            seg
);

    localparam int CNT_W  = $clog2(SLOT_CYC);
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_V   = CNT_W'(BLANK_CYC);
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(BLINK_SCANS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        dig;
    logic [15:0]       active;
    logic [15:0]       pend_data;
    logic              pending;
    logic              phase;
    logic [SCAN_W-1:0] scan_cnt;

    logic              tick;
    logic              scan_end;
    logic              xfer;
    logic [3:0]        nib;
    logic [6:0]        seg_dec;
    logic              blank_now;

    assign tick         = (cnt == LAST_CNT);
    assign scan_end     = tick && (dig == 2'd3);
    assign bus.in_ready = !pending;
    assign xfer         = bus.in_valid && !pending;

    always_comb begin
        nib     = active[{dig, 2'b00} +: 4];
        seg_dec = 7'h3F;
        case (nib)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    end

    // Clearing blink_en lights the display on the very next output, without
    // waiting for the registered phase to be forced back on.
    // dig[0] selects digits 1 and 3, the only ones subject to zero blanking.
    assign blank_now = (cnt < BLANK_V)
                     || (blink_en && !phase)
                     || (lz_en && dig[0] && (nib == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dig       <= 2'd0;
            active    <= 16'h0000;
            pend_data <= 16'h0000;
            pending   <= 1'b0;
            phase     <= 1'b1;
            scan_cnt  <= '0;
            an        <= 4'b1111;
            seg       <= 7'h7F;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                dig <= dig + 2'd1;
            end

            // xfer needs pending=0, so it can never collide with a commit.
            // A word taken in the scan_end cycle waits for the following scan_end.
            if (scan_end && pending) begin
                active  <= pend_data;
                pending <= 1'b0;
            end else if (xfer) begin
                pend_data <= bus.in_data;
                pending   <= 1'b1;
            end

            if (!blink_en) begin
                phase    <= 1'b1;
                scan_cnt <= '0;
            end else if (scan_end) begin
                if (scan_cnt == LAST_SCAN) begin
                    scan_cnt <= '0;
                    phase    <= ~phase;
                end else begin
                    scan_cnt <= scan_cnt + 1'b1;
                end
            end

            if (blank_now) begin
                an  <= 4'b1111;
                seg <= 7'h7F;
            end else begin
                an  <= ~(4'b0001 << dig);
                seg <= seg_dec;
            end
        end
    end

endmodule
